ps2_rx_fifo: RTL

Parametrised PS/2 keyboard receiver for the custom 8-bit computer. It runs on the system clock rather than on the keyboard clock, and validates every frame: start bit, odd parity, stop bit and an inter-bit timeout. It tracks the E0 (extended) and F0 (break) prefixes and queues decoded key events in a show-ahead FIFO, which the CPU I/O port drains. It replaces the single-register keyboard latch and has no debounce heuristic.

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_sync_fifo.sv | 72 +++++++
 rtl/ps2_rx_fifo.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types, constants and the scancode-to-ASCII helper for the PS/2 receiver.
// The helper is only referenced when PS2_ASCII_EN is defined.
package ps2_pkg;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] data;
  } ps2_entry_t;

  // Scan-code set 2 to ASCII; returns 0 for unmapped codes.
  function automatic logic [7:0] ps2_to_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    if (shift && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
    return a;
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty and a sticky overflow flag.
// A write while full is accepted only if a pop happens in the same cycle.
module ps2_sync_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             wr_ack_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Aw:0]      count_q, count_d;
  logic             empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en_i && !empty_q;
    do_wr    = wr_en_i && (!full_q || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + Aw'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + Aw'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + (Aw+1)'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - (Aw+1)'(1);
    end
    full_d  = (count_d == (Aw+1)'(Depth));
    empty_d = (count_d == '0);
    ovf_d   = ovf_q || (wr_en_i && !do_wr);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Gate the head so the outputs read zero while empty, including after reset.
  assign rd_data_o  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign wr_ack_o   = do_wr;
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver on the system clock: frame checks, E0/F0 prefix tracking, event FIFO.
// Define PS2_ASCII_EN to queue ASCII make events instead of raw scancodes.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic       RD_EN,
  output logic [7:0] DATA_OUT,
  output logic       EXT_OUT,
  output logic       BRK_OUT,
  output logic       EMPTY,
  output logic       FULL,
  output logic       OVERFLOW,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic [7:0] LEDR
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d, bit_stb_q, bit_stb_d, bit_dat_q, bit_dat_d;
  rx_state_e              state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   par_ok_q, par_ok_d;
  logic [ToW-1:0]         to_cnt_q, to_cnt_d;
  logic                   byte_done_q, byte_done_d;
  logic                   par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                   ext_q, ext_d, brk_q, brk_d;
  logic [7:0]             ledr_q, ledr_d;
  logic                   push, push_ack;
  ps2_entry_t             push_entry;
  logic [9:0]             head;
`ifdef PS2_ASCII_EN
  logic                   shift_q, shift_d;
  logic [7:0]             ascii;
`endif

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
    bit_stb_d  = clk_prev_q && !clk_sync_q[SYNC_STAGES-1];
    bit_dat_d  = dat_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_ok_d    = par_ok_q;
    byte_done_d = 1'b0;
    par_err_d   = 1'b0;
    frm_err_d   = 1'b0;
    if (state_q == StIdle || bit_stb_q) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == ToLast) begin
      // Inter-bit gap too long: abandon the partial byte.
      to_cnt_d  = '0;
      frm_err_d = 1'b1;
      state_d   = StIdle;
    end else begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
    if (bit_stb_q) begin
      unique case (state_q)
        StIdle: begin
          if (!bit_dat_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shreg_d   = {bit_dat_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_ok_d = (^shreg_q) ^ bit_dat_q;
          state_d  = StStop;
        end
        StStop: begin
          if (bit_dat_q && par_ok_q) byte_done_d = 1'b1;
          else if (bit_dat_q)        par_err_d   = 1'b1;
          else                       frm_err_d   = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    push       = 1'b0;
    push_entry = '0;
`ifdef PS2_ASCII_EN
    shift_d    = shift_q;
    ascii      = ps2_to_ascii(shreg_q, shift_q);
`endif
    if (par_err_q || frm_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_done_q) begin
      if (shreg_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (shreg_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
`ifdef PS2_ASCII_EN
        if (shreg_q == PS2_LSHIFT || shreg_q == PS2_RSHIFT) begin
          shift_d = !brk_q;
        end else if (!brk_q && ascii != 8'h00) begin
          push       = 1'b1;
          push_entry = '{ext: ext_q, brk: 1'b0, data: ascii};
        end
`else
        push       = 1'b1;
        push_entry = '{ext: ext_q, brk: brk_q, data: shreg_q};
`endif
      end
    end
    ledr_d = push_ack ? push_entry.data : ledr_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      clk_prev_q  <= 1'b1;
      bit_stb_q   <= 1'b0;
      bit_dat_q   <= 1'b1;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      byte_done_q <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      ledr_q      <= '0;
`ifdef PS2_ASCII_EN
      shift_q     <= 1'b0;
`endif
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      clk_prev_q  <= clk_prev_d;
      bit_stb_q   <= bit_stb_d;
      bit_dat_q   <= bit_dat_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_ok_q    <= par_ok_d;
      to_cnt_q    <= to_cnt_d;
      byte_done_q <= byte_done_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      ledr_q      <= ledr_d;
`ifdef PS2_ASCII_EN
      shift_q     <= shift_d;
`endif
    end
  end

  ps2_sync_fifo #(
    .Width (10),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .wr_en_i    (push),
    .wr_data_i  (push_entry),
    .rd_en_i    (RD_EN),
    .rd_data_o  (head),
    .wr_ack_o   (push_ack),
    .empty_o    (EMPTY),
    .full_o     (FULL),
    .overflow_o (OVERFLOW)
  );

  assign {EXT_OUT, BRK_OUT, DATA_OUT} = head;
  assign PARITY_ERR = par_err_q;
  assign FRAME_ERR  = frm_err_q;
  assign LEDR       = ledr_q;

endmodule
